// File: rtl/enemy_collision_detector_if.sv
// Bundle between the enemy controller and the collision detector:
// snapshot inputs, per-enemy results and the done strobe.
interface enemy_collision_detector_if;
    logic       start;
    logic [8:0] link_x_pos;
    logic [7:0] link_y_pos;
    logic       link_attack;
    logic [2:0] link_direction;
    logic [2:0] enemy_active;
    logic [8:0] enemy_1_x_pos;
    logic [8:0] enemy_2_x_pos;
    logic [8:0] enemy_3_x_pos;
    logic [7:0] enemy_1_y_pos;
    logic [7:0] enemy_2_y_pos;
    logic [7:0] enemy_3_y_pos;
    logic [2:0] enemy_1_direction;
    logic [2:0] enemy_2_direction;
    logic [2:0] enemy_3_direction;
    logic [2:0] collision;
    logic [2:0] hit;
    logic       link_hurt;
    logic       done;

    modport master (
        output start, link_x_pos, link_y_pos, link_attack, link_direction,
        output enemy_active,
        output enemy_1_x_pos, enemy_2_x_pos, enemy_3_x_pos,
        output enemy_1_y_pos, enemy_2_y_pos, enemy_3_y_pos,
        output enemy_1_direction, enemy_2_direction, enemy_3_direction,
        input  collision, hit, link_hurt, done
    );

    modport slave (
        input  start, link_x_pos, link_y_pos, link_attack, link_direction,
        input  enemy_active,
        input  enemy_1_x_pos, enemy_2_x_pos, enemy_3_x_pos,
        input  enemy_1_y_pos, enemy_2_y_pos, enemy_3_y_pos,
        input  enemy_1_direction, enemy_2_direction, enemy_3_direction,
        output collision, hit, link_hurt, done
    );
endinterface

// File: rtl/enemy_collision_detector.sv
// Snapshots Link/enemy state on start, evaluates one enemy per cycle,
// then commits collision/hit/link_hurt together with a done pulse.
module enemy_collision_detector #(
    parameter int SPRITE = 16,
    parameter int STEP   = 1,
    parameter int X_MIN  = 16,
    parameter int X_MAX  = 288,
    parameter int Y_MIN  = 16,
    parameter int Y_MAX  = 208
) (
    input logic clock,
    input logic reset,
    enemy_collision_detector_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EVAL, COMMIT} state_t;
    typedef logic signed [10:0] coord_t;

    localparam coord_t     SP     = coord_t'(SPRITE);
    localparam logic [9:0] STEP_X = 10'(STEP);
    localparam logic [8:0] STEP_Y = 9'(STEP);
    localparam logic [9:0] XMIN_C = 10'(X_MIN);
    localparam logic [9:0] XMAX_C = 10'(X_MAX);
    localparam logic [8:0] YMIN_C = 9'(Y_MIN);
    localparam logic [8:0] YMAX_C = 9'(Y_MAX);

    state_t     state_q, state_d;
    logic [1:0] idx_q;

    logic [8:0] lx_q;
    logic [7:0] ly_q;
    logic       atk_q;
    logic [2:0] ldir_q;
    logic [2:0] act_q;
    logic [8:0] ex_q [3];
    logic [7:0] ey_q [3];
    logic [2:0] ed_q [3];

    logic [2:0] coll_s, hit_s;
    logic       hurt_s;
    logic [2:0] coll_q, hit_q;
    logic       hurt_q, done_q;

    function automatic logic overlap(
        input coord_t ax, input coord_t ay,
        input coord_t bx, input coord_t by
    );
        return (ax < bx + SP) && (bx < ax + SP) &&
               (ay < by + SP) && (by < ay + SP);
    endfunction

    logic [8:0] cx;
    logic [7:0] cy;
    logic [2:0] cd;
    logic       ca;
    logic [9:0] px;
    logic [8:0] py;
    logic       under, oob, obst;
    coord_t     lsx, lsy, csx, csy, psx, psy, swx, swy;
    logic       sv;
    logic       block_b, hit_b, hurt_b;

    always_comb begin
        cx = '0;
        cy = '0;
        cd = '0;
        ca = 1'b0;
        for (int j = 0; j < 3; j++) begin
            if (idx_q == 2'(j)) begin
                cx = ex_q[j];
                cy = ey_q[j];
                cd = ed_q[j];
                ca = act_q[j];
            end
        end

        px    = {1'b0, cx};
        py    = {1'b0, cy};
        under = 1'b0;
        case (cd)
            3'd1: begin
                under = ({1'b0, cy} < STEP_Y);
                py    = {1'b0, cy} - STEP_Y;
            end
            3'd2: py = {1'b0, cy} + STEP_Y;
            3'd3: begin
                under = ({1'b0, cx} < STEP_X);
                px    = {1'b0, cx} - STEP_X;
            end
            3'd4: px = {1'b0, cx} + STEP_X;
            default: ;
        endcase
        oob = under || (px < XMIN_C) || (px > XMAX_C) ||
              (py < YMIN_C) || (py > YMAX_C);

        lsx = coord_t'({2'b00, lx_q});
        lsy = coord_t'({3'b000, ly_q});
        csx = coord_t'({2'b00, cx});
        csy = coord_t'({3'b000, cy});
        psx = coord_t'({1'b0, px});
        psy = coord_t'({2'b00, py});

        obst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            if (idx_q != 2'(j) && act_q[j] &&
                overlap(psx, psy,
                        coord_t'({2'b00, ex_q[j]}),
                        coord_t'({3'b000, ey_q[j]})))
                obst = 1'b1;
        end

        // Sword sits one sprite ahead of Link; may extend past 0.
        swx = lsx;
        swy = lsy;
        sv  = 1'b1;
        unique case (1'b1)
            (ldir_q == 3'd1): swy = lsy - SP;
            (ldir_q == 3'd2): swy = lsy + SP;
            (ldir_q == 3'd3): swx = lsx - SP;
            (ldir_q == 3'd4): swx = lsx + SP;
            default:          sv  = 1'b0;
        endcase

        block_b = ca && (oob || obst || overlap(psx, psy, lsx, lsy));
        hit_b   = ca && atk_q && sv && overlap(swx, swy, csx, csy);
        hurt_b  = ca && overlap(csx, csy, lsx, lsy);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = EVAL;
            EVAL:    if (idx_q == 2'd2) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            coll_s  <= '0;
            hit_s   <= '0;
            hurt_s  <= 1'b0;
            coll_q  <= '0;
            hit_q   <= '0;
            hurt_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        idx_q  <= '0;
                        coll_s <= '0;
                        hit_s  <= '0;
                        hurt_s <= 1'b0;
                    end
                end
                EVAL: begin
                    coll_s[idx_q] <= block_b;
                    hit_s[idx_q]  <= hit_b;
                    hurt_s        <= hurt_s | hurt_b;
                    idx_q         <= idx_q + 2'd1;
                end
                COMMIT: begin
                    coll_q <= coll_s;
                    hit_q  <= hit_s;
                    hurt_q <= hurt_s;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Snapshot registers need no reset: only read after a start.
    always_ff @(posedge clock) begin
        if (state_q == IDLE && bus.start) begin
            lx_q    <= bus.link_x_pos;
            ly_q    <= bus.link_y_pos;
            atk_q   <= bus.link_attack;
            ldir_q  <= bus.link_direction;
            act_q   <= bus.enemy_active;
            ex_q[0] <= bus.enemy_1_x_pos;
            ex_q[1] <= bus.enemy_2_x_pos;
            ex_q[2] <= bus.enemy_3_x_pos;
            ey_q[0] <= bus.enemy_1_y_pos;
            ey_q[1] <= bus.enemy_2_y_pos;
            ey_q[2] <= bus.enemy_3_y_pos;
            ed_q[0] <= bus.enemy_1_direction;
            ed_q[1] <= bus.enemy_2_direction;
            ed_q[2] <= bus.enemy_3_direction;
        end
    end

    assign bus.collision = coll_q;
    assign bus.hit       = hit_q;
    assign bus.link_hurt = hurt_q;
    assign bus.done      = done_q;
endmodule

// File: doc/enemy_collision_detector.md
Name: enemy_collision_detector

Overview:
Sequential collision/hit evaluator that feeds the `collision[2:0]` and `hit[2:0]` inputs of the three-enemy controller. It consumes Link's position and attack state plus each enemy's position, direction and alive flag, and takes a snapshot on `start`. It then evaluates one enemy per cycle and commits all results atomically with a one-cycle `done` pulse. The control FSM issues `start` before the enemy `gen_move`/`apply_move` phase.

Parameters:
SPRITE, 16, sprite edge length in pixels (square boxes)
STEP, 1, pixels an enemy moves per apply_move
X_MIN, 16, smallest legal sprite top-left x
X_MAX, 288, largest legal sprite top-left x
Y_MIN, 16, smallest legal sprite top-left y
Y_MAX, 208, largest legal sprite top-left y

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  request evaluation; sampled only in IDLE
link_x_pos  in  9  Link top-left x
link_y_pos  in  8  Link top-left y
link_attack  in  1  Link sword active
link_direction  in  3  Link facing direction
enemy_active  in  3  bit i = enemy i alive
enemy_1_x_pos / enemy_2_x_pos / enemy_3_x_pos  in  9 each  enemy top-left x
enemy_1_y_pos / enemy_2_y_pos / enemy_3_y_pos  in  8 each  enemy top-left y
enemy_1_direction / enemy_2_direction / enemy_3_direction  in  3 each  enemy proposed move
collision  out  3  bit i = enemy i's proposed move is blocked
hit  out  3  bit i = enemy i struck by sword
link_hurt  out  1  some live enemy overlaps Link
done  out  1  one-cycle pulse; results valid

Behaviour:
- Clock is `clock`. Reset is `reset`, synchronous and active-high.
- Reset values: `collision` = 0, `hit` = 0, `link_hurt` = 0, `done` = 0, FSM in IDLE. Reset applies in any state and aborts evaluation; no `done` is produced for the aborted run.
- Direction encoding: 000 stationary, 001 up (y-STEP), 010 down (y+STEP), 011 left (x-STEP), 100 right (x+STEP). Codes 101–111 are treated as stationary.
- FSM states: IDLE, EVAL, COMMIT.
  - IDLE: on `start`=1, snapshot all inputs into registers, set idx=0, go to EVAL.
  - EVAL: evaluate enemy idx into shadow bits; idx increments each cycle; after idx=2, go to COMMIT.
  - COMMIT: copy shadows to `collision`/`hit`/`link_hurt`, assert `done`=1 for exactly this cycle, return to IDLE.
- Latency: `start` sampled at edge T. Enemies are evaluated in cycles T+1..T+3. Outputs change and `done`=1 in cycle T+4. `start` can be accepted again at edge T+5.
- `start` while not IDLE is ignored. Mid-run input changes have no effect (snapshot only).
- Outputs hold their values between commits.
- Overlap(A,B): ax < bx+SPRITE && bx < ax+SPRITE && ay < by+SPRITE && by < ay+SPRITE.
- Arithmetic widths: x math in 10 bits, y math in 9 bits, unsigned. Out-of-range is detected before any truncation.
- Projected position P_i = enemy i position + direction step.
  - If the subtraction would go below 0, the move counts as out of bounds.
- collision[i] = active[i] && (P_i.x < X_MIN || P_i.x > X_MAX || P_i.y < Y_MIN || P_i.y > Y_MAX || Overlap(P_i, Link) || Overlap(P_i, current box of any active enemy j≠i)).
- Sword box = Link box shifted SPRITE pixels in `link_direction`.
  - Shift may go negative. The shifted box uses signed 11-bit coordinates.
  - Stationary/invalid direction gives no sword box.
- hit[i] = active[i] && link_attack && Overlap(sword box, enemy i current box).
- link_hurt = OR over active i of Overlap(enemy i current box, Link).
- Inactive enemies always produce collision=0 and hit=0, and are never obstacles.

Test Plan:
- Reset asserted 2 cycles, then released with no `start` -> collision=000, hit=000, link_hurt=0, done stays 0.
- Enemy1 (16,100) dir 011; enemy2/enemy3 at (200,50)/(250,180) stationary; Link (100,150); active=111; `start` at T -> done=1 only at T+4, collision=001, hit=000, link_hurt=0.
- Link (100,100) dir 100 with link_attack=1; enemy2 (116,100) stationary; others far -> hit=010, link_hurt=0, collision=000.
- Enemy1 (50,50) dir 100; enemy3 (66,50) stationary -> collision=001 (enemy3 unblocked: 66<66 false).
- `start` at T, second `start` at T+2, reset at T+3 -> no done pulse, outputs 000/000/0. Fresh `start` then completes normally.
- active=011, enemy3 overlapping Link and inside the sword box -> link_hurt=0, hit[2]=0, collision[2]=0.
